mem_access_unit: RTL

//  Load/store initiator on the datapath side of data_memory. Takes one CPU

---
 rtl/mem_access_unit_pkg.sv | 33 +++
 rtl/mem_access_unit_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store initiator in front of data_memory.
// Provides the width defaults, the access-size encodings, the FSM state type and a
// helper that flags misaligned or illegal requests.
package mem_access_unit_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Returns 1 when the request can never reach memory. This covers a halfword
    // on an odd byte, a word that is not on a word boundary, and the unused size code.
    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//  word        in   32  memory word (load source / RMW base)
//  addr_lo     in   2   byte offset within the word
//  size        in   2   SIZE_B / SIZE_H / SIZE_W
//  is_unsigned in   1   zero-extend loads when 1
//  wdata       in   32  right-justified store data
//  load_data   out  32  extracted and extended load value
//  store_word  out  32  word with the target lane(s) replaced by wdata
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = word[{addr_lo, 3'b000} +: 8];
        lane_h     = word[{addr_lo[1], 4'b0000} +: 16];
        load_data  = word;
        store_word = wdata;
        case (size)
            SIZE_B: begin
                load_data  = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
                store_word = word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_H: begin
                load_data  = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                store_word = word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator in front of a word-only data_memory. Sub-word stores
// are done as a read followed by a write (read-modify-write).
//  clk, rst (async, active-low)
//  req_valid/req_ready/req_write/req_size/req_unsigned/req_addr/req_wdata : CPU request
//  resp_valid/resp_rdata/misalign_err : one-cycle completion with load data / error
//  mem_read_flag/mem_write_flag/mem_addr/mem_write_data/mem_read_data : data_memory side
//
//  state | meaning
//  IDLE  | ready, waiting for req_valid
//  RD    | memory read (load, or first half of a sub-word store)
//  WR    | memory write of the full word
//  RESP  | resp_valid pulse, then back to IDLE
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int DATA_W = DATA_LEN
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              misalign_err,
    output logic              mem_read_flag,
    output logic              mem_write_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] align_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    // During RD the lane extraction works on the live memory data; during WR it
    // merges into the word captured at the end of RD.
    assign align_word = (state_q == ST_RD) ? mem_read_data : word_q;

    mem_lane_align u_align (
        .word        (align_word),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = is_bad_req(req_size, req_addr[1:0]);
                    if (is_bad_req(req_size, req_addr[1:0])) begin
                        state_d = ST_RESP;
                    end else if (req_write && (req_size == SIZE_W)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                word_d = mem_read_data;
                if (write_q) begin
                    state_d = ST_WR;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            default: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        resp_valid     = (state_q == ST_RESP);
        mem_read_flag  = (state_q == ST_RD);
        mem_write_flag = (state_q == ST_WR);
        mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
        mem_write_data = (state_q == ST_WR) ? store_word : '0;
        resp_rdata     = rdata_q;
        misalign_err   = err_q;
    end

endmodule
